// File: rtl/a_ctrl_stim_ram_64.sv
// rtl/a_ctrl_stim_ram_64.sv - stimulus RAM read controller with 2-entry prefetch buffer
//
// Walks the stimulus RAM from address 0 to a programmable last address and keeps
// a two-word prefetch buffer in front of the stimulus generator. The head of the
// buffer is always presented on stimu_o. One-shot or looping playback.
//
// Ports:
//   clk_ref        reference clock, all logic on the rising edge
//   rst            synchronous reset, active-high
//   start_i        1-cycle pulse: latch last_addr_i/loop_i, flush, restart at address 0
//   last_addr_i    last RAM address played (inclusive)
//   loop_i         1: wrap to 0 after last address, 0: stop after last address
//   r_incr_i       generator consumed the current stimu_o word
//   ram_en_o       RAM read enable
//   ram_addr_o     RAM read address
//   ram_data_i     RAM read data, valid the cycle after ram_en_o
//   stimu_o        head word of the prefetch buffer
//   stimu_valid_o  stimu_o holds a valid word
//   done_o         one-shot playback complete
//   underrun_o     sticky: r_incr_i seen while the buffer was empty

module a_ctrl_stim_ram_64 #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int DATA_W = 64
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    input  logic              loop_i,
    input  logic              r_incr_i,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [DATA_W-1:0] stimu_o,
    output logic              stimu_valid_o,
    output logic              done_o,
    output logic              underrun_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   last_addr_q;
    logic                loop_q;
    logic [1:0]          count_q;
    // inflight_q marks that ram_data_i carries the word for a read issued last cycle
    logic                inflight_q;
    logic [DATA_W-1:0]   buf0_q;
    logic [DATA_W-1:0]   buf1_q;
    logic                underrun_q;

    logic                pop;
    logic [2:0]          occ;
    logic                issue;
    logic                at_last;
    logic [ADDR_W-1:0]   addr_nxt;

    always_comb begin
        pop      = 1'b0;
        occ      = 3'd0;
        issue    = 1'b0;
        at_last  = 1'b0;
        addr_nxt = '0;

        pop     = r_incr_i && (count_q != 2'd0);
        // Words held plus word in flight, less the one leaving this cycle, must
        // leave room for the read we are about to issue.
        occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue   = (state_q == RUN) && (occ < 3'd2);
        at_last = (addr_q == last_addr_q);
        if (at_last || (addr_q == ADDR_W'(DEPTH - 1))) begin
            addr_nxt = '0;
        end else begin
            addr_nxt = addr_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = IDLE;
            RUN:   if (issue && at_last && !loop_q) state_d = DRAIN;
            DRAIN: if ((count_q == 2'd0) && !inflight_q) state_d = DONE;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (start_i) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            loop_q      <= 1'b0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            underrun_q  <= 1'b0;
        end else if (start_i) begin
            // Restart: a read still in flight is dropped by clearing inflight_q.
            state_q     <= state_d;
            addr_q      <= '0;
            last_addr_q <= last_addr_i;
            loop_q      <= loop_i;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                addr_q <= addr_nxt;
            end
            if (r_incr_i && (count_q == 2'd0)) begin
                underrun_q <= 1'b1;
            end
            case ({pop, inflight_q})
                2'b11: begin
                    // Capture and pop together: occupancy unchanged, head advances.
                    if (count_q == 2'd1) begin
                        buf0_q <= ram_data_i;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= ram_data_i;
                    end
                end
                2'b10: begin
                    buf0_q  <= buf1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) begin
                        buf0_q <= ram_data_i;
                    end else begin
                        buf1_q <= ram_data_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ram_en_o      = issue;
    assign ram_addr_o    = addr_q;
    assign stimu_o       = buf0_q;
    assign stimu_valid_o = (count_q != 2'd0);
    assign done_o        = (state_q == DONE);
    assign underrun_o    = underrun_q;

endmodule

// File: doc/a_ctrl_stim_ram_64.md
Name: a_ctrl_stim_ram_64

Overview:
- Stimulus RAM read controller that sits directly upstream of the 64-bit stimulus generator/demux stage.
- Walks the stimulus RAM, 8192 x 64, synchronous read with 1-cycle latency, from address 0 to a programmable last address.
- Prefetches words into a 2-entry buffer so that stimu_o always holds the next stimulus word.
- Advances one word per r_incr_i pulse from the generator.
- Supports one-shot or looping playback and flags completion and underrun.

Parameters:
ADDR_W, 13, RAM address width
DEPTH, 8192, RAM depth (2**ADDR_W)
DATA_W, 64, stimulus word width

Ports:
clk_ref  in  1  reference clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start_i  in  1  1-cycle pulse: sample last_addr_i/loop_i, flush, restart at address 0
last_addr_i  in  ADDR_W  last RAM address played (inclusive)
loop_i  in  1  1: wrap to 0 after last_addr; 0: stop
r_incr_i  in  1  generator consumed current stimu_o word (pop)
ram_en_o  out  1  RAM read enable
ram_addr_o  out  ADDR_W  RAM read address
ram_data_i  in  DATA_W  RAM read data, valid the cycle after ram_en_o
stimu_o  out  DATA_W  head word of prefetch buffer
stimu_valid_o  out  1  stimu_o holds a valid word
done_o  out  1  one-shot playback complete
underrun_o  out  1  sticky: r_incr_i seen while buffer empty

Behaviour:
- Reset (rst=1 at edge): state IDLE, addr=0, count=0, inflight=0. All outputs 0; stimu_o=0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DRAIN when the read of last_addr is issued with loop=0.
  - DRAIN -> DONE when count=0 and inflight=0.
  - DONE -> RUN on start_i.
  - start_i in any state restarts (see below).
- start_i sampled at edge T:
  - Latch last_addr and loop.
  - Buffer flushed (count=0); any in-flight read is discarded (its data is not written).
  - addr=0; underrun_o, done_o and stimu_valid_o cleared.
- Read issue, combinational in RUN:
  - ram_en_o=1 when (count + inflight - pop) < 2, where pop = r_incr_i & stimu_valid_o.
  - ram_addr_o=addr.
  - On issue: inflight<=1; addr<=addr+1, or addr<=0 if addr==last_addr.
  - ram_en_o=0 in IDLE/DRAIN/DONE.
- Capture: the cycle after an issue, ram_data_i is written into the buffer. Word order is strictly address order.
- Latency from start_i at edge T:
  - ram_en_o=1, addr 0 during cycle T+1.
  - Data captured at edge T+2.
  - stimu_valid_o=1 and stimu_o=word0 from T+2 to the next edge.
- Throughput: with r_incr_i held high every cycle, one word is delivered per cycle with no bubble after the initial fill.
- Simultaneous capture and pop in the same cycle: count unchanged; the head advances to the next word.
- Pop while empty (r_incr_i=1, stimu_valid_o=0): ignored, no state change; underrun_o<=1. underrun_o stays 1 until start_i or rst.
- stimu_o and stimu_valid_o are registered. stimu_o holds its value when not popped.
- last_addr=0, loop=0: exactly one word is played. last_addr=DEPTH-1: addr wraps 8191->0 naturally.
- done_o=1 in DONE only.
- Loop mode never reaches DRAIN/DONE; it stops only on start_i or rst.
- rst mid-operation: immediate return to reset values; a pending RAM read is ignored.

Test Plan:
- Reset, then start_i with last_addr=3, loop=0, RAM[i]=i+0x100, r_incr_i held high -> stimu_o 0x100,0x101,0x102,0x103 on 4 consecutive cycles starting T+2; done_o=1 two cycles after the last pop; exactly 4 ram_en_o pulses.
- last_addr=2, loop=1, r_incr_i every cycle for 8 cycles -> sequence 0x100,0x101,0x102,0x100,... ; ram_addr_o wraps 2->0; done_o stays 0.
- No r_incr_i after start -> buffer fills to 2 (addresses 0,1 read), ram_en_o then 0; stimu_o=0x100 held; a single pop -> stimu_o=0x101 next cycle and addr 2 issued the same cycle.
- r_incr_i pulse at T+1 (before first data) -> underrun_o=1 and sticky; word0 is still delivered at T+2; the next start_i clears underrun_o.
- start_i asserted mid-run while a read is in flight (addr 5) -> in-flight data dropped; stimu_o=RAM[0] 2 cycles later.
- rst=1 mid-run for 1 cycle -> all outputs 0 next cycle; no further ram_en_o until start_i.
